// File: rtl/ppu_pkg.sv
// ============================================================================
// Module : ppu_pkg
// Brief  : Shared PPU types and default sizing for the background pipeline.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppu_pkg;

    localparam int c_bg_fifo_depth  = 16;
    localparam int c_screen_x_max   = 160;
    localparam int c_row_pixels     = 8;

    typedef logic [1:0] pixel_t;

endpackage

`default_nettype wire

// File: rtl/bg_pixel_fifo_evt_counter.sv
// ============================================================================
// Module : EvtCounter
// Brief  : Saturating event counter with enable and synchronous clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module EvtCounter #(
    parameter int MAX = 160,
    parameter int W   = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         en_in,
    input  logic         clr_in,
    input  logic         inc_in,
    output logic [W-1:0] count_out
);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_out <= '0;
        end else if (en_in) begin
            if (clr_in) begin
                count_out <= '0;
            end else if (inc_in && (count_out != W'(MAX))) begin
                count_out <= count_out + W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bg_pixel_fifo.sv
// ============================================================================
// Module : bg_pixel_fifo
// Brief  : Background pixel FIFO: 8-pixel row pushes, 1-pixel pops per T-cycle.
//          Define BG_FIFO_FINE_SCROLL_EN to discard SCX[2:0] leading pixels.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bg_pixel_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = c_bg_fifo_depth,
    parameter int X_MAX = c_screen_x_max
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     tclk_in,
    input  logic                     line_start_in,
    input  logic                     flush_in,
    input  logic                     stall_in,
    input  logic [7:0]               SCX_in,
    input  logic                     valid_pixels_in,
    input  pixel_t                   pixels_in [7:0],
    output logic                     empty_out,
    output pixel_t                   pixel_out,
    output logic                     pixel_valid_out,
    output logic [$clog2(X_MAX)-1:0] X_out,
    output logic                     line_done_out,
    output logic                     overflow_out
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_x_w   = $clog2(X_MAX);

    pixel_t             r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [2:0]         r_discard;

    logic               w_push_req;
    logic               w_push_ok;
    logic               w_push_drop;
    logic               w_pop;
    logic               w_visible;
    logic [2:0]         w_discard_load;
    logic               w_unused;

    // Line start and flush pre-empt any push or pop in the same tick.
    assign w_push_req  = valid_pixels_in && !line_start_in && !flush_in;
    assign w_push_ok   = w_push_req && (r_count <= c_cnt_w'(DEPTH - c_row_pixels));
    assign w_push_drop = w_push_req && !w_push_ok;
    assign w_pop       = !line_start_in && !flush_in && (r_count != '0)
                         && !stall_in && !line_done_out;

`ifdef BG_FIFO_FINE_SCROLL_EN
    assign w_visible      = w_pop && (r_discard == 3'd0);
    assign w_discard_load = SCX_in[2:0];
    assign w_unused       = ^SCX_in[7:3];
`else
    assign w_visible      = w_pop;
    assign w_discard_load = 3'd0;
    assign w_unused       = ^{SCX_in, r_discard};
`endif

    assign empty_out     = (r_count == '0);
    assign line_done_out = (X_out == c_x_w'(X_MAX));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            r_discard       <= 3'd0;
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
            overflow_out    <= 1'b0;
        end else if (tclk_in) begin
            if (line_start_in) begin
                r_rd_ptr        <= '0;
                r_wr_ptr        <= '0;
                r_count         <= '0;
                r_discard       <= w_discard_load;
                pixel_valid_out <= 1'b0;
            end else if (flush_in) begin
                r_rd_ptr        <= '0;
                r_wr_ptr        <= '0;
                r_count         <= '0;
                pixel_valid_out <= 1'b0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(c_row_pixels);
                if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_count <= r_count
                           + (w_push_ok ? c_cnt_w'(c_row_pixels) : c_cnt_w'(0))
                           - (w_pop     ? c_cnt_w'(1)            : c_cnt_w'(0));
                if (w_push_drop) overflow_out <= 1'b1;
                pixel_valid_out <= w_visible;
                if (w_visible) pixel_out <= r_mem[r_rd_ptr];
                if (w_pop && !w_visible) r_discard <= r_discard - 3'd1;
            end
        end
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk_in) begin
        if (tclk_in && w_push_ok) begin
            for (int i = 0; i < c_row_pixels; i++) begin
                r_mem[r_wr_ptr + c_ptr_w'(i)] <= pixels_in[i];
            end
        end
    end

    EvtCounter #(
        .MAX (X_MAX),
        .W   (c_x_w)
    ) u_x_counter (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (tclk_in),
        .clr_in    (line_start_in),
        .inc_in    (w_visible),
        .count_out (X_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_bg_pixel_fifo.sv
// ============================================================================
// Module : tb_bg_pixel_fifo
// Brief  : Self-checking bench for bg_pixel_fifo against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bg_pixel_fifo;
    import ppu_pkg::*;

    localparam int DEPTH = 16;
    localparam int X_MAX = 160;
    localparam int XW    = $clog2(X_MAX);
`ifdef BG_FIFO_FINE_SCROLL_EN
    localparam bit FINE = 1'b1;
`else
    localparam bit FINE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tclk = 1'b0, ls = 1'b0, fl = 1'b0, st = 1'b0, vld = 1'b0;
    logic [7:0]    scx = 8'd0;
    pixel_t        row [7:0];
    logic          empty, pv, ld, ovf;
    pixel_t        pix;
    logic [XW-1:0] xo;

    bg_pixel_fifo #(.DEPTH(DEPTH), .X_MAX(X_MAX)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .tclk_in         (tclk),
        .line_start_in   (ls),
        .flush_in        (fl),
        .stall_in        (st),
        .SCX_in          (scx),
        .valid_pixels_in (vld),
        .pixels_in       (row),
        .empty_out       (empty),
        .pixel_out       (pix),
        .pixel_valid_out (pv),
        .X_out           (xo),
        .line_done_out   (ld),
        .overflow_out    (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a pixel queue plus a handful of scalar counters.
    pixel_t mq[$];
    int     mx, mdisc;
    bit     mpv, movf;
    pixel_t mpix;

    function automatic void model_reset();
        mq.delete(); mx = 0; mdisc = 0; mpv = 0; movf = 0; mpix = 2'd0;
    endfunction

    function automatic void model_step();
        int pre;
        pixel_t p;
        if (ls) begin
            mq.delete(); mx = 0; mpv = 0;
            mdisc = FINE ? int'(scx[2:0]) : 0;
        end else if (fl) begin
            mq.delete(); mpv = 0;
        end else begin
            pre = mq.size();
            mpv = 0;
            if (pre > 0 && !st && mx != X_MAX) begin
                p = mq.pop_front();
                if (mdisc > 0) mdisc--;
                else begin mpix = p; mpv = 1; mx++; end
            end
            if (vld) begin
                if (pre <= DEPTH - 8) for (int i = 0; i < 8; i++) mq.push_back(row[i]);
                else movf = 1;
            end
        end
    endfunction

    task automatic do_tick(input bit t, input bit l, input bit f, input bit s,
                           input bit v, input logic [7:0] sc, input logic [15:0] r);
        tclk = t; ls = l; fl = f; st = s; vld = v; scx = sc;
        for (int i = 0; i < 8; i++) row[i] = r[2*i +: 2];
        @(posedge clk);
        if (t) model_step();
        #1;
    endtask

    function automatic logic [13:0] dut_obs();
        return {pv, (pv ? pix : 2'd0), xo, ld, empty, ovf};
    endfunction

    function automatic logic [13:0] model_obs();
        return {mpv, (mpv ? mpix : 2'd0), XW'(mx), (mx == X_MAX), (mq.size() == 0), movf};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pv, pix, xo, ld, empty, ovf} !== {1'b0, 2'd0, XW'(0), 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %b required %b", {pv, pix, xo, ld, empty, ovf},
                     {1'b0, 2'd0, XW'(0), 1'b0, 1'b1, 1'b0});
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_row();
        int nvalid = 0;
        do_tick(1, 1, 0, 0, 0, 8'd0, 16'h0);
        do_tick(1, 0, 0, 0, 1, 8'd0, 16'hE4E4);
        for (int i = 0; i < 12; i++) begin
            do_tick(1, 0, 0, 0, 0, 8'd0, 16'h0);
            if (pv) nvalid++;
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL basic_row tick %0d: got %h required %h", i, dut_obs(), model_obs());
            end
        end
        checks++;
        if (nvalid !== 8 || xo !== XW'(8) || empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_row_totals: got valid=%0d X=%0d empty=%b required 8 8 1",
                     nvalid, xo, empty);
        end
    endtask

    task automatic test_fine_scroll();
        int nvalid = 0;
        int first = -1;
        do_tick(1, 1, 0, 0, 0, 8'd5, 16'h0);
        do_tick(1, 0, 0, 0, 1, 8'd5, 16'hE4E4);
        for (int i = 0; i < 12; i++) begin
            do_tick(1, 0, 0, 0, 0, 8'd5, 16'h0);
            if (pv) begin
                if (first < 0) first = int'(pix);
                nvalid++;
            end
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL fine_scroll tick %0d: got %h required %h", i, dut_obs(), model_obs());
            end
        end
        checks++;
        if (nvalid !== (FINE ? 3 : 8) || first !== (FINE ? 1 : 0) || xo !== XW'(FINE ? 3 : 8)) begin
            errors++;
            $display("FAIL fine_scroll_totals: got valid=%0d first=%0d X=%0d", nvalid, first, xo);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] r;
        do_tick(1, 1, 0, 0, 0, 8'd0, 16'h0);
        do_tick(1, 0, 0, 1, 1, 8'd0, 16'h1B1B);       // count 8
        do_tick(1, 0, 0, 0, 1, 8'd0, 16'hE4E4);       // push+pop -> 15
        repeat (6) do_tick(1, 0, 0, 0, 0, 8'd0, 16'h0); // drain to 9
        checks++;
        if (mq.size() !== 9 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_setup: model count=%0d ovf=%b required 9 0", mq.size(), ovf);
        end
        do_tick(1, 0, 0, 1, 1, 8'd0, 16'hFFFF);       // dropped at 9
        checks++;
        if (ovf !== 1'b1 || dut_obs() !== model_obs()) begin
            errors++;
            $display("FAIL overflow_drop: got %h required %h", dut_obs(), model_obs());
        end
        do_tick(1, 0, 0, 0, 0, 8'd0, 16'h0);          // 8
        r = 16'(($urandom() & 32'hFFFF));
        do_tick(1, 0, 0, 1, 1, 8'd0, r);              // accepted -> 16
        for (int i = 0; i < 20; i++) begin
            do_tick(1, 0, 0, 0, 0, 8'd0, 16'h0);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL overflow_drain tick %0d: got %h required %h", i, dut_obs(), model_obs());
            end
        end
    endtask

    task automatic test_stall();
        do_tick(1, 1, 0, 0, 0, 8'd0, 16'h0);
        do_tick(1, 0, 0, 1, 1, 8'd0, 16'(($urandom() & 32'hFFFF)));
        for (int i = 0; i < 6; i++) begin
            do_tick(1, 0, 0, 1, 0, 8'd0, 16'h0);
            checks++;
            if (pv !== 1'b0 || dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL stall tick %0d: got %h required %h", i, dut_obs(), model_obs());
            end
        end
        for (int i = 0; i < 10; i++) begin
            do_tick(1, 0, 0, 0, 0, 8'd0, 16'h0);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL stall_release tick %0d: got %h required %h", i, dut_obs(), model_obs());
            end
        end
    endtask

    task automatic test_full_line();
        int nvalid = 0;
        int bad = 0;
        do_tick(1, 1, 0, 0, 0, 8'd0, 16'h0);
        for (int i = 0; i < 200; i++) begin
            do_tick(1, 0, 0, 0, 1, 8'd0, 16'(($urandom() & 32'hFFFF)));
            if (pv) nvalid++;
            if (dut_obs() !== model_obs()) bad++;
        end
        checks++;
        if (nvalid !== 160 || xo !== XW'(160) || ld !== 1'b1 || bad !== 0) begin
            errors++;
            $display("FAIL full_line: got valid=%0d X=%0d done=%b tick_mismatches=%0d required 160 160 1 0",
                     nvalid, xo, ld, bad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            do_tick(($urandom_range(3) != 0), ($urandom_range(39) == 0), ($urandom_range(39) == 0),
                    ($urandom_range(4) == 0), ($urandom_range(3) == 0),
                    8'($urandom()), 16'(($urandom() & 32'hFFFF)));
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL random tick %0d: got %h required %h", i, dut_obs(), model_obs());
            end
        end
    endtask

    task automatic test_flush_reset();
        int guard = 0;
        do_tick(1, 1, 0, 0, 0, 8'd0, 16'h0);
        while (mx + mq.size() < 45 && guard < 200) begin
            do_tick(1, 0, 0, 0, (mq.size() <= 8), 8'd0, 16'(($urandom() & 32'hFFFF)));
            guard++;
        end
        while (mx < 43 && guard < 200) begin
            do_tick(1, 0, 0, 0, 0, 8'd0, 16'h0);
            guard++;
        end
        checks++;
        if (mq.size() !== 5 || xo !== XW'(43)) begin
            errors++;
            $display("FAIL flush_setup: got X=%0d model count=%0d required 43 5", xo, mq.size());
        end
        do_tick(1, 0, 1, 0, 1, 8'd0, 16'hFFFF);
        checks++;
        if (empty !== 1'b1 || xo !== XW'(43) || pv !== 1'b0 || dut_obs() !== model_obs()) begin
            errors++;
            $display("FAIL flush: got %h required %h", dut_obs(), model_obs());
        end
        do_tick(1, 0, 0, 0, 1, 8'd0, 16'h1B1B);
        do_tick(1, 0, 0, 0, 0, 8'd0, 16'h0);
        checks++;
        if (dut_obs() !== model_obs() || xo !== XW'(44)) begin
            errors++;
            $display("FAIL flush_resume: got %h required %h", dut_obs(), model_obs());
        end
        // Assert reset between edges while a push is being presented.
        tclk = 1'b1; vld = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({pv, pix, xo, ld, empty, ovf} !== {1'b0, 2'd0, XW'(0), 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %b required %b", {pv, pix, xo, ld, empty, ovf},
                     {1'b0, 2'd0, XW'(0), 1'b0, 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        vld = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_tick(1, 0, 0, 0, 0, 8'd0, 16'h0);
        checks++;
        if (dut_obs() !== model_obs()) begin
            errors++;
            $display("FAIL post_reset: got %h required %h", dut_obs(), model_obs());
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) row[i] = 2'd0;
        model_reset();
        test_reset();
        test_basic_row();
        test_fine_scroll();
        test_overflow();
        test_stall();
        test_full_line();
        test_random();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
